jtpopeye_objdma: RTL and testbench
==================================

# jtpopeye_objdma

Object-attribute DMA engine fed by the video timing generator. On each rising edge of vertical blank it requests the CPU bus, copies a fixed-length block of object attributes from CPU work RAM into the object line-buffer attribute RAM, then releases the bus. It sits between the timing generator (VB), the CPU bus arbiter (BUSRQ/BUSAK) and the object renderer's attribute store.

## Interface
Parameters:
- AW, 10, CPU-side source address width
- LEN, 160, number of bytes copied per frame (1..256)
- BASE, 10'h000, first source address

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pxl_cen  in  1  pixel clock enable; one DMA step per pulse
- VB  in  1  vertical blank from timing generator
- dma_en  in  1  level; DMA triggers only if high at the VB rising edge
- busak_n  in  1  CPU bus acknowledge, active low
- busrq_n  out  1  CPU bus request, active low
- dma_addr  out  AW  source RAM address
- dma_din  in  8  source RAM data, valid one pxl_cen step after dma_addr
- obj_addr  out  8  attribute RAM write address
- obj_dout  out  8  attribute RAM write data
- obj_we  out  1  attribute RAM write strobe
- dma_busy  out  1  high from trigger until bus release
- dma_ovr  out  1  sticky abort flag, cleared at next trigger

## Operation
- All state, including VB edge detection (registered VB_l), advances only on clk cycles with pxl_cen=1; outputs other than obj_we hold between enables.
- States: IDLE, REQ, COPY, REL.
- IDLE: on VB && !VB_l && dma_en -> busrq_n=0, dma_busy=1, dma_ovr=0, idx=0, state REQ. VB edge with dma_en=0 ignored.
- REQ: wait busak_n==0 (sampled on enable) -> dma_addr=BASE, idx=0, state COPY.
- COPY: two-stage pipeline. Each enable: sample dma_din for address presented at previous enable, write it to obj_addr=idx-1 (not on first enable of COPY); present dma_addr=BASE+idx while idx<LEN; idx increments. After the write of byte LEN-1 -> state REL.
- REL: busrq_n=1, dma_busy=0, state IDLE.
- dma_addr arithmetic: BASE+idx truncated to AW bits (wraps at 2^AW). obj_addr = idx-1 in 8 bits; LEN=256 fills 0..255.
- Abort: VB sampled low while in REQ or COPY -> no further writes, busrq_n=1, dma_busy=0, dma_ovr=1, state IDLE on that same enable. An abort and a final write on the same enable: abort wins, write suppressed.
- busak_n deasserted mid-COPY is a bus protocol violation; block continues, not checked.
- Reset (any state, mid-transfer included): state IDLE, busrq_n=1, dma_busy=0, dma_ovr=0, obj_we=0, dma_addr=BASE, obj_addr=0, obj_dout=0, VB_l=1 (a reset during VB does not trigger a DMA).

## Timing
- Trigger to busrq_n low: 1 enable after the enable where VB first reads high.
- Grant to first dma_addr: same enable busak_n is sampled low.
- dma_din is sampled on the enable following its address; obj_dout/obj_addr update on that enable; obj_we is high for exactly one clk, the clk cycle after that enable.
- Full transfer after grant: LEN+1 enables in COPY, 1 in REL; busrq_n high LEN+2 enables after grant.
- Exactly LEN obj_we pulses per completed transfer; at most one per enable.

## Test plan
- Reset then VB rise with dma_en=1, busak_n tied 0, LEN=160, RAM[i]=i^8'h5A -> 160 obj_we pulses, obj RAM[k]=k^8'h5A, busrq_n back high 162 enables after grant, dma_ovr=0.
- dma_en=0 at VB rise -> busrq_n stays 1, no obj_we, dma_busy=0 whole frame.
- busak_n held high 20 enables after request -> no dma_addr change, no writes until grant; then full 160-byte copy.
- VB falls after 50 writes -> writes stop at obj_addr=49, busrq_n=1 and dma_ovr=1 on that enable; next VB rise clears dma_ovr and copies all 160.
- rst asserted during COPY at idx=80 -> all outputs at reset values next clk; no trigger while VB stays high; next VB rise performs full copy.
- BASE=10'h3F0, LEN=32 -> dma_addr sequence 3F0..3FF, 000..00F; obj_addr 0..31.

Source files
------------

// File: rtl/jtpopeye_objdma.sv
// Object-attribute DMA: on each VB rising edge, takes the CPU bus and copies LEN
// bytes from work RAM (starting at BASE) into the object attribute RAM.
module jtpopeye_objdma #(
    parameter int              AW   = 10,
    parameter int              LEN  = 160,
    parameter logic [AW-1:0]   BASE = '0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          VB,
    input  logic          dma_en,
    input  logic          busak_n,
    output logic          busrq_n,
    output logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_din,
    output logic [7:0]    obj_addr,
    output logic [7:0]    obj_dout,
    output logic          obj_we,
    output logic          dma_busy,
    output logic          dma_ovr
);

    typedef enum logic [1:0] {IDLE, REQ, COPY, REL} state_t;

    state_t        st, st_nxt;
    logic          vb_l;
    logic [8:0]    idx, idx_nxt;
    logic          busrq_nxt, busy_nxt, ovr_nxt, we_nxt;
    logic [AW-1:0] addr_nxt;
    logic [7:0]    oaddr_nxt, odout_nxt;
    logic          abort;

    // Losing VB before the block is done means the frame timing is gone; drop out.
    assign abort = !VB && (st == REQ || st == COPY);

    always_comb begin
        st_nxt    = st;
        idx_nxt   = idx;
        busrq_nxt = busrq_n;
        busy_nxt  = dma_busy;
        ovr_nxt   = dma_ovr;
        addr_nxt  = dma_addr;
        oaddr_nxt = obj_addr;
        odout_nxt = obj_dout;
        we_nxt    = 1'b0;
        if (abort) begin
            busrq_nxt = 1'b1;
            busy_nxt  = 1'b0;
            ovr_nxt   = 1'b1;
            st_nxt    = IDLE;
        end else begin
            case (st)
                IDLE: if (VB && !vb_l && dma_en) begin
                    busrq_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    ovr_nxt   = 1'b0;
                    idx_nxt   = '0;
                    st_nxt    = REQ;
                end
                REQ: if (!busak_n) begin
                    addr_nxt = BASE;
                    idx_nxt  = '0;
                    st_nxt   = COPY;
                end
                COPY: begin
                    // Data returned now belongs to the address presented last enable.
                    if (idx != '0) begin
                        we_nxt    = 1'b1;
                        oaddr_nxt = 8'(idx - 9'd1);
                        odout_nxt = dma_din;
                    end
                    if (idx < 9'(LEN))
                        addr_nxt = BASE + AW'(idx);
                    idx_nxt = idx + 9'd1;
                    if (idx == 9'(LEN))
                        st_nxt = REL;
                end
                REL: begin
                    busrq_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    st_nxt    = IDLE;
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            vb_l     <= 1'b1;   // no trigger if reset is released inside VB
            idx      <= '0;
            busrq_n  <= 1'b1;
            dma_busy <= 1'b0;
            dma_ovr  <= 1'b0;
            dma_addr <= BASE;
            obj_addr <= '0;
            obj_dout <= '0;
            obj_we   <= 1'b0;
        end else begin
            obj_we <= pxl_cen & we_nxt;
            if (pxl_cen) begin
                st       <= st_nxt;
                vb_l     <= VB;
                idx      <= idx_nxt;
                busrq_n  <= busrq_nxt;
                dma_busy <= busy_nxt;
                dma_ovr  <= ovr_nxt;
                dma_addr <= addr_nxt;
                obj_addr <= oaddr_nxt;
                obj_dout <= odout_nxt;
            end
        end
    end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Bench for jtpopeye_objdma: two instances (default, and BASE=3F0/LEN=32) checked
// every clock against a transfer-level model, plus directed literal expectations.
module tb_jtpopeye_objdma;

    logic clk, rst, pxl_cen, VB, dma_en, busak_n;
    logic busrq0, busy0, ovr0, we0, busrq1, busy1, ovr1, we1;
    logic [9:0] addr0, addr1;
    logic [7:0] din0, din1, oaddr0, oaddr1, odout0, odout1;
    logic [7:0] src [0:1023];

    assign din0 = src[addr0];
    assign din1 = src[addr1];

    jtpopeye_objdma u0 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(VB), .dma_en(dma_en),
        .busak_n(busak_n), .busrq_n(busrq0), .dma_addr(addr0), .dma_din(din0),
        .obj_addr(oaddr0), .obj_dout(odout0), .obj_we(we0), .dma_busy(busy0), .dma_ovr(ovr0));

    jtpopeye_objdma #(.AW(10), .LEN(32), .BASE(10'h3F0)) u1 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(VB), .dma_en(dma_en),
        .busak_n(busak_n), .busrq_n(busrq1), .dma_addr(addr1), .dma_din(din1),
        .obj_addr(oaddr1), .obj_dout(odout1), .obj_we(we1), .dma_busy(busy1), .dma_ovr(ovr1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- transfer-level model ----------------
    function automatic int len_of(input int i);
        return (i == 0) ? 160 : 32;
    endfunction
    function automatic logic [9:0] base_of(input int i);
        return (i == 0) ? 10'h000 : 10'h3F0;
    endfunction

    logic c_rst, c_cen, c_vb, c_en, c_bak, m_on;
    int   m_mode [2];     // 0 idle, 1 waiting for grant, 2 granted
    int   m_k    [2];     // enables elapsed since grant
    logic m_vbl  [2];
    logic e_busrq[2], e_busy[2], e_ovr[2], e_we[2];
    logic [9:0] e_addr[2];
    logic [7:0] e_oaddr[2], e_odout[2];
    logic [7:0] objmem [2][256];
    int   cnt_we [2];

    task automatic m_abort(input int i);
        e_busrq[i] = 1'b1; e_busy[i] = 1'b0; e_ovr[i] = 1'b1; m_mode[i] = 0;
    endtask

    task automatic model_step(input int i);
        logic [9:0] b;
        int L;
        logic rise;
        b = base_of(i);
        L = len_of(i);
        e_we[i] = 1'b0;
        if (c_rst) begin
            m_mode[i] = 0; m_vbl[i] = 1'b1; e_busrq[i] = 1'b1; e_busy[i] = 1'b0; e_ovr[i] = 1'b0;
            e_addr[i] = b; e_oaddr[i] = 8'h00; e_odout[i] = 8'h00;
            return;
        end
        if (!c_cen) return;
        rise = c_vb && !m_vbl[i];
        m_vbl[i] = c_vb;
        case (m_mode[i])
            0: if (rise && c_en) begin
                e_busrq[i] = 1'b0; e_busy[i] = 1'b1; e_ovr[i] = 1'b0; m_mode[i] = 1;
            end
            1: if (!c_vb) m_abort(i);
               else if (!c_bak) begin e_addr[i] = b; m_k[i] = 0; m_mode[i] = 2; end
            default: begin
                m_k[i]++;
                if (m_k[i] == L + 2) begin
                    e_busrq[i] = 1'b1; e_busy[i] = 1'b0; m_mode[i] = 0;
                end else if (!c_vb) m_abort(i);
                else begin
                    // byte j = k-2 arrives at enable k; address for byte k-1 goes out at k
                    if (m_k[i] <= L) e_addr[i] = b + 10'(m_k[i] - 1);
                    if (m_k[i] >= 2) begin
                        e_we[i]    = 1'b1;
                        e_oaddr[i] = 8'(m_k[i] - 2);
                        e_odout[i] = src[b + 10'(m_k[i] - 2)];
                    end
                end
            end
        endcase
    endtask

    initial begin
        logic g_busrq[2], g_busy[2], g_ovr[2], g_we[2];
        logic [9:0] g_addr[2];
        logic [7:0] g_oaddr[2], g_odout[2];
        m_on = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cnt_we[i] = 0; m_mode[i] = 0; m_k[i] = 0;
            for (int a = 0; a < 256; a++) objmem[i][a] = 8'h00;
        end
        forever begin
            @(posedge clk);
            c_rst = rst; c_cen = pxl_cen; c_vb = VB; c_en = dma_en; c_bak = busak_n;
            #2;
            if (c_rst) m_on = 1'b1;
            g_busrq[0] = busrq0; g_busy[0] = busy0; g_ovr[0] = ovr0; g_we[0] = we0;
            g_addr[0] = addr0; g_oaddr[0] = oaddr0; g_odout[0] = odout0;
            g_busrq[1] = busrq1; g_busy[1] = busy1; g_ovr[1] = ovr1; g_we[1] = we1;
            g_addr[1] = addr1; g_oaddr[1] = oaddr1; g_odout[1] = odout1;
            for (int i = 0; i < 2; i++) begin
                model_step(i);
                if (m_on) begin
                    chk($sformatf("u%0d.busrq_n", i),  32'(g_busrq[i]), 32'(e_busrq[i]));
                    chk($sformatf("u%0d.dma_busy", i), 32'(g_busy[i]),  32'(e_busy[i]));
                    chk($sformatf("u%0d.dma_ovr", i),  32'(g_ovr[i]),   32'(e_ovr[i]));
                    chk($sformatf("u%0d.obj_we", i),   32'(g_we[i]),    32'(e_we[i]));
                    chk($sformatf("u%0d.dma_addr", i), 32'(g_addr[i]),  32'(e_addr[i]));
                    chk($sformatf("u%0d.obj_addr", i), 32'(g_oaddr[i]), 32'(e_oaddr[i]));
                    chk($sformatf("u%0d.obj_dout", i), 32'(g_odout[i]), 32'(e_odout[i]));
                    if (g_we[i] === 1'b1) begin
                        objmem[i][g_oaddr[i]] = g_odout[i];
                        cnt_we[i]++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_busrq(input logic lvl, input int lim, input string nm);
        for (int t = 0; t < lim; t++) begin
            @(posedge clk); #1;
            if (busrq0 === lvl) return;
        end
        n_chk++; n_err++;
        $display("FAIL timeout %s t=%0t actual=%b required=%b", nm, $time, busrq0, lvl);
    endtask

    task automatic wait_writes(input int n, input int lim, input string nm);
        int w;
        w = 0;
        for (int t = 0; t < lim; t++) begin
            @(posedge clk); #1;
            if (we0 === 1'b1) w++;
            if (w == n) return;
        end
        n_chk++; n_err++;
        $display("FAIL timeout %s t=%0t actual=%0d required=%0d", nm, $time, w, n);
    endtask

    initial begin
        int n, c0, flag;
        logic [9:0] a0;
        rst = 1'b1; pxl_cen = 1'b1; VB = 1'b0; dma_en = 1'b1; busak_n = 1'b0;
        for (int k = 0; k < 1024; k++) src[k] = 8'(k) ^ 8'h5A;
        tick(3);
        rst = 1'b0;
        chk("rst.busrq_n", 32'(busrq0), 32'h1);
        chk("rst.dma_busy", 32'(busy0), 32'h0);
        chk("rst.dma_addr1", 32'(addr1), 32'h3F0);

        // full copy with bus granted immediately
        tick(2);
        VB = 1'b1;
        wait_busrq(1'b0, 10, "p1_req");
        @(posedge clk);
        n = 0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1; n++;
            if (busrq0 === 1'b1) break;
        end
        chk("p1.grant_to_release", 32'(n), 32'd162);
        tick(3);
        VB = 1'b0;
        tick(3);
        chk("p1.count0", 32'(cnt_we[0]), 32'd160);
        chk("p1.count1", 32'(cnt_we[1]), 32'd32);
        chk("p1.obj0[0]", 32'(objmem[0][0]), 32'h5A);
        chk("p1.obj0[1]", 32'(objmem[0][1]), 32'h5B);
        chk("p1.obj0[159]", 32'(objmem[0][159]), 32'hC5);
        chk("p1.obj1[0]", 32'(objmem[1][0]), 32'hAA);
        chk("p1.obj1[16]", 32'(objmem[1][16]), 32'h5A);
        chk("p1.obj1[31]", 32'(objmem[1][31]), 32'h55);
        chk("p1.ovr", 32'(ovr0), 32'h0);

        // disabled frame
        dma_en = 1'b0; c0 = cnt_we[0]; flag = 0;
        VB = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick(1);
            if (busrq0 !== 1'b1 || busy0 !== 1'b0 || we0 !== 1'b0) flag = 1;
        end
        VB = 1'b0; dma_en = 1'b1;
        tick(3);
        chk("p2.idle_frame", 32'(flag), 32'd0);
        chk("p2.no_writes", 32'(cnt_we[0] - c0), 32'd0);

        // delayed grant
        busak_n = 1'b1; flag = 0;
        VB = 1'b1;
        wait_busrq(1'b0, 10, "p3_req");
        a0 = addr0;
        for (int t = 0; t < 20; t++) begin
            tick(1);
            if (addr0 !== a0 || we0 !== 1'b0) flag = 1;
        end
        chk("p3.hold_until_grant", 32'(flag), 32'd0);
        c0 = cnt_we[0];
        busak_n = 1'b0;
        wait_busrq(1'b1, 400, "p3_rel");
        tick(2);
        chk("p3.count", 32'(cnt_we[0] - c0), 32'd160);
        VB = 1'b0;
        tick(5);

        // VB drops after 50 writes
        c0 = cnt_we[0];
        VB = 1'b1;
        wait_writes(50, 400, "p4_50");
        VB = 1'b0;
        tick(1);
        chk("p4.busrq_n", 32'(busrq0), 32'h1);
        chk("p4.ovr", 32'(ovr0), 32'h1);
        chk("p4.busy", 32'(busy0), 32'h0);
        chk("p4.last_addr", 32'(oaddr0), 32'd49);
        tick(5);
        chk("p4.count", 32'(cnt_we[0] - c0), 32'd50);
        c0 = cnt_we[0];
        VB = 1'b1;
        wait_busrq(1'b0, 10, "p4_req");
        chk("p4.ovr_cleared", 32'(ovr0), 32'h0);
        wait_busrq(1'b1, 400, "p4_rel");
        tick(2);
        chk("p4.recopy", 32'(cnt_we[0] - c0), 32'd160);
        VB = 1'b0;
        tick(5);

        // reset in the middle of a copy
        VB = 1'b1;
        wait_writes(79, 400, "p5_79");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("p5.busrq_n", 32'(busrq0), 32'h1);
        chk("p5.busy", 32'(busy0), 32'h0);
        chk("p5.ovr", 32'(ovr0), 32'h0);
        chk("p5.we", 32'(we0), 32'h0);
        chk("p5.dma_addr", 32'(addr0), 32'h0);
        chk("p5.obj_addr", 32'(oaddr0), 32'h0);
        chk("p5.obj_dout", 32'(odout0), 32'h0);
        chk("p5.dma_addr1", 32'(addr1), 32'h3F0);
        flag = 0;
        for (int t = 0; t < 50; t++) begin
            tick(1);
            if (busrq0 !== 1'b1) flag = 1;
        end
        chk("p5.no_trigger_in_vb", 32'(flag), 32'd0);
        VB = 1'b0;
        tick(5);
        c0 = cnt_we[0];
        VB = 1'b1;
        wait_busrq(1'b0, 10, "p5_req");
        wait_busrq(1'b1, 400, "p5_rel");
        tick(2);
        chk("p5.recopy", 32'(cnt_we[0] - c0), 32'd160);
        VB = 1'b0;
        tick(5);

        // randomized frames: enable gaps, grant jitter, short VB, sporadic reset
        for (int k = 0; k < 1024; k++) src[k] = 8'($urandom);
        for (int f = 0; f < 30; f++) begin
            dma_en = ($urandom_range(0, 9) != 0);
            n = int'($urandom_range(3, 20));
            VB = 1'b0;
            for (int t = 0; t < n; t++) begin
                pxl_cen = ($urandom_range(0, 3) != 0);
                busak_n = ($urandom_range(0, 4) == 0);
                tick(1);
            end
            n = int'($urandom_range(20, 450));
            VB = 1'b1;
            for (int t = 0; t < n; t++) begin
                pxl_cen = ($urandom_range(0, 3) != 0);
                busak_n = ($urandom_range(0, 4) == 0);
                rst = ($urandom_range(0, 299) == 0);
                tick(1);
            end
            rst = 1'b0;
        end
        pxl_cen = 1'b1; VB = 1'b0;
        tick(5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
